// File: rtl/uart_io_resp.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_resp
// Description : UART request responder between the exec stage and the byte
//               transceiver. It serialises 1-4 byte words MSB-first to TX and
//               assembles 1-4 RX bytes from a FIFO into a zero-extended word.
//               Define UART_IO_OVERRUN_EN to add the rx_overrun flag and its
//               rx_overrun_clr input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_io_resp #(
    parameter int RX_FIFO_DEPTH = 16,
    parameter int RX_PTR_W      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_wenable,
    input  logic [1:0]  uart_wsz,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    input  logic [1:0]  uart_rsz,
    output logic [31:0] uart_rd,
    output logic        uart_rdone,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        w_busy,
`ifdef UART_IO_OVERRUN_EN
    input  logic        rx_overrun_clr,
    output logic        rx_overrun,
`endif
    output logic        r_busy
);

    localparam logic [1:0] c_W_IDLE    = 2'd0;
    localparam logic [1:0] c_W_SEND    = 2'd1;
    localparam logic [1:0] c_W_DONE    = 2'd2;
    localparam logic [1:0] c_R_IDLE    = 2'd0;
    localparam logic [1:0] c_R_COLLECT = 2'd1;
    localparam logic [1:0] c_R_DONE    = 2'd2;
    localparam logic [RX_PTR_W:0] c_PTR_ONE = {{RX_PTR_W{1'b0}}, 1'b1};

    logic [1:0]          r_wstate;
    logic [31:0]         r_wdata;
    logic [2:0]          r_wcnt;
    logic [1:0]          r_rstate;
    logic [2:0]          r_rcnt;
    logic [23:0]         r_acc;
    logic [RX_PTR_W:0]   r_wptr;
    logic [RX_PTR_W:0]   r_rptr;
    logic [7:0]          r_mem [RX_FIFO_DEPTH];

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic [7:0]          w_rbyte;

    // ------------------------------------------------------------------------
    // Write engine: the word is pre-aligned so the next byte is always [31:24]
    // and zeros shift in behind it, leaving tx_data at 0 once the word is sent.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate   <= c_W_IDLE;
            r_wdata    <= '0;
            r_wcnt     <= '0;
            tx_valid   <= 1'b0;
            uart_wdone <= 1'b0;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    uart_wdone <= 1'b0;
                    if (uart_wenable) begin
                        r_wdata  <= uart_wd << {~uart_wsz, 3'b000};
                        r_wcnt   <= {1'b0, uart_wsz} + 3'd1;
                        tx_valid <= 1'b1;
                        r_wstate <= c_W_SEND;
                    end
                end
                c_W_SEND: begin
                    if (tx_ready) begin
                        r_wdata <= {r_wdata[23:0], 8'h00};
                        r_wcnt  <= r_wcnt - 3'd1;
                        if (r_wcnt == 3'd1) begin
                            tx_valid   <= 1'b0;
                            uart_wdone <= 1'b1;
                            r_wstate   <= c_W_DONE;
                        end
                    end
                end
                c_W_DONE: begin
                    uart_wdone <= 1'b0;
                    r_wstate   <= c_W_IDLE;
                end
                default: r_wstate <= c_W_IDLE;
            endcase
        end
    end

    assign tx_data = r_wdata[31:24];
    assign w_busy  = (r_wstate != c_W_IDLE);

    // ------------------------------------------------------------------------
    // RX FIFO: extra pointer bit separates full from empty
    // ------------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[RX_PTR_W] != r_rptr[RX_PTR_W]) &&
                     (r_wptr[RX_PTR_W-1:0] == r_rptr[RX_PTR_W-1:0]);
    assign w_pop   = (r_rstate == c_R_COLLECT) && !w_empty;
    // A pop in the same cycle frees the slot being written, so a full push is safe
    assign w_push  = rx_valid && (!w_full || w_pop);
    assign w_rbyte = r_mem[r_rptr[RX_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[RX_PTR_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
        end
    end

`ifdef UART_IO_OVERRUN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_overrun <= 1'b0;
        end else if (rx_valid && w_full && !w_pop) begin
            rx_overrun <= 1'b1;
        end else if (rx_overrun_clr) begin
            rx_overrun <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Read engine: first byte popped ends up most significant
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate   <= c_R_IDLE;
            r_rcnt     <= '0;
            r_acc      <= '0;
            uart_rd    <= '0;
            uart_rdone <= 1'b0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    uart_rdone <= 1'b0;
                    if (uart_renable) begin
                        r_rcnt   <= {1'b0, uart_rsz} + 3'd1;
                        r_acc    <= '0;
                        r_rstate <= c_R_COLLECT;
                    end
                end
                c_R_COLLECT: begin
                    if (w_pop) begin
                        r_acc  <= {r_acc[15:0], w_rbyte};
                        r_rcnt <= r_rcnt - 3'd1;
                        if (r_rcnt == 3'd1) begin
                            uart_rd    <= {r_acc, w_rbyte};
                            uart_rdone <= 1'b1;
                            r_rstate   <= c_R_DONE;
                        end
                    end
                end
                c_R_DONE: begin
                    uart_rdone <= 1'b0;
                    r_rstate   <= c_R_IDLE;
                end
                default: r_rstate <= c_R_IDLE;
            endcase
        end
    end

    assign r_busy = (r_rstate != c_R_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_io_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_io_resp
// Description : Directed and randomised self-checking bench for uart_io_resp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_io_resp;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        uart_wenable = 1'b0;
    logic [1:0]  uart_wsz = '0;
    logic [31:0] uart_wd = '0;
    logic        uart_wdone;
    logic        uart_renable = 1'b0;
    logic [1:0]  uart_rsz = '0;
    logic [31:0] uart_rd;
    logic        uart_rdone;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        w_busy;
    logic        r_busy;
`ifdef UART_IO_OVERRUN_EN
    logic        rx_overrun_clr = 1'b0;
    logic        rx_overrun;
`endif

    int          compared = 0;
    int          mismatched = 0;
    int          ready_mode = 0;
    int          wdone_cnt = 0;
    int          rdone_cnt = 0;
    logic [7:0]  tx_log[$];
    logic [7:0]  fifo_q[$];

    uart_io_resp #(.RX_FIFO_DEPTH(DEPTH), .RX_PTR_W(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_wenable (uart_wenable),
        .uart_wsz     (uart_wsz),
        .uart_wd      (uart_wd),
        .uart_wdone   (uart_wdone),
        .uart_renable (uart_renable),
        .uart_rsz     (uart_rsz),
        .uart_rd      (uart_rd),
        .uart_rdone   (uart_rdone),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .w_busy       (w_busy),
`ifdef UART_IO_OVERRUN_EN
        .rx_overrun_clr (rx_overrun_clr),
        .rx_overrun     (rx_overrun),
`endif
        .r_busy       (r_busy)
    );

    always #5 clk = ~clk;

    // tx_ready driver: fixed low, fixed high or random per cycle
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (uart_wdone) wdone_cnt++;
        if (uart_rdone) rdone_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte i (0 = first sent) of an n-byte write
    function automatic logic [7:0] wbyte(input logic [31:0] wd, input int n, input int i);
        logic [31:0] t;
        t = wd >> (8 * (n - 1 - i));
        return t[7:0];
    endfunction

    // Single-cycle RX strobe; the model drops when full (no read is active here)
    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        if (fifo_q.size() < DEPTH) fifo_q.push_back(b);
    endtask

    // Read with n bytes already buffered: value from the model, latency n edges
    task automatic read_check(input logic [1:0] rsz, input string tag);
        int n;
        int c;
        logic [31:0] exp;
        n = int'(rsz) + 1;
        exp = 0;
        for (int i = 0; i < n; i++) exp = exp * 256 + 32'(fifo_q.pop_front());
        uart_rsz = rsz;
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        c = 0;
        while (!uart_rdone && c < 40) begin
            tick();
            c++;
        end
        check({tag, "_lat"}, 32'(c), 32'(n));
        check({tag, "_rd"}, uart_rd, exp);
        tick();
    endtask

    task automatic write_check(input logic [1:0] wsz, input logic [31:0] wd, input string tag);
        int n;
        int c;
        int wd0;
        n = int'(wsz) + 1;
        tx_log.delete();
        wd0 = wdone_cnt;
        uart_wsz = wsz;
        uart_wd = wd;
        uart_wenable = 1'b1;
        tick();
        uart_wenable = 1'b0;
        c = 0;
        while (!uart_wdone && c < 200) begin
            if ($urandom_range(0, 3) == 0) push(8'($urandom));
            else tick();
            c++;
        end
        check({tag, "_done"}, 32'(uart_wdone), 32'd1);
        tick();
        check({tag, "_cnt"}, 32'(tx_log.size()), 32'(n));
        check({tag, "_pulses"}, 32'(wdone_cnt - wd0), 32'd1);
        for (int i = 0; i < n && i < tx_log.size(); i++)
            check({tag, "_byte"}, 32'(tx_log[i]), 32'(wbyte(wd, n, i)));
    endtask

    initial begin
        int c;
        int snap;
        logic [7:0] b4 [4];
        logic [31:0] rnd;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_wdone", 32'(uart_wdone), 0);
        check("rst_rdone", 32'(uart_rdone), 0);
        check("rst_rd", uart_rd, 0);
        check("rst_busy", {30'd0, w_busy, r_busy}, 0);
`ifdef UART_IO_OVERRUN_EN
        check("rst_overrun", 32'(rx_overrun), 0);
`endif
        rstn = 1'b1;
        ready_mode = 1;
        tick();

        // ---------------- DEADBEEF, full-rate ----------------
        tx_log.delete();
        uart_wd = 32'hDEADBEEF;
        uart_wsz = 2'd3;
        uart_wenable = 1'b1;
        tick();
        uart_wenable = 1'b0;
        check("w4_busy", 32'(w_busy), 1);
        for (int i = 0; i < 4; i++) begin
            check("w4_valid", 32'(tx_valid), 1);
            check("w4_data", 32'(tx_data), 32'(wbyte(32'hDEADBEEF, 4, i)));
            tick();
        end
        check("w4_wdone", 32'(uart_wdone), 1);
        check("w4_valid_off", 32'(tx_valid), 0);
        tick();
        check("w4_wdone_off", 32'(uart_wdone), 0);
        check("w4_idle", 32'(w_busy), 0);
        check("w4_log", 32'(tx_log.size()), 4);

        // ---------------- single byte with backpressure ----------------
        ready_mode = 0;
        tick();
        uart_wd = 32'h00000041;
        uart_wsz = 2'd0;
        uart_wenable = 1'b1;
        tick();
        uart_wenable = 1'b0;
        tx_log.delete();
        for (int i = 0; i < 5; i++) begin
            check("w1_hold", {23'd0, tx_valid, tx_data}, 32'h141);
            tick();
        end
        ready_mode = 1;
        tick();
        check("w1_wdone", 32'(uart_wdone), 1);
        tick();
        check("w1_log", 32'(tx_log.size()), 1);
        if (tx_log.size() > 0) check("w1_byte", 32'(tx_log[0]), 32'h41);

        // ---------------- buffered read ----------------
        push(8'h12);
        push(8'h34);
        push(8'h56);
        read_check(2'd2, "r3");
        check("r3_value", uart_rd, 32'h00123456);
        check("r3_idle", 32'(r_busy), 0);

        // FIFO must be empty now: a 1-byte read stalls until a new byte arrives
        snap = rdone_cnt;
        uart_rsz = 2'd0;
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        repeat (4) tick();
        check("empty_stall", 32'(rdone_cnt - snap), 0);
        check("empty_busy", 32'(r_busy), 1);
        push(8'h77);
        void'(fifo_q.pop_front());
        tick();
        check("empty_rdone", 32'(uart_rdone), 1);
        check("empty_rd", uart_rd, 32'h77);
        tick();

        // ---------------- slow arrivals ----------------
        for (int i = 0; i < 4; i++) b4[i] = 8'($urandom);
        snap = rdone_cnt;
        uart_rsz = 2'd3;
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (10) tick();
            push(b4[i]);
        end
        check("slow_no_early", 32'(rdone_cnt - snap), 0);
        check("slow_busy", 32'(r_busy), 1);
        tick();
        check("slow_rdone", 32'(uart_rdone), 1);
        check("slow_rd", uart_rd, {b4[0], b4[1], b4[2], b4[3]});
        repeat (4) void'(fifo_q.pop_front());
        tick();

        // ---------------- overflow ----------------
        for (int i = 1; i <= 17; i++) push(8'(i));
        check("ovf_model", 32'(fifo_q.size()), DEPTH);
`ifdef UART_IO_OVERRUN_EN
        check("ovf_flag", 32'(rx_overrun), 1);
        rx_data = 8'hEE;
        rx_valid = 1'b1;
        rx_overrun_clr = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("ovf_set_wins", 32'(rx_overrun), 1);
        tick();
        rx_overrun_clr = 1'b0;
        check("ovf_cleared", 32'(rx_overrun), 0);
`endif
        // Full FIFO, push coinciding with a pop must be kept
        uart_rsz = 2'd0;
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("full_pop_rdone", 32'(uart_rdone), 1);
        check("full_pop_rd", uart_rd, 32'h01);
`ifdef UART_IO_OVERRUN_EN
        check("full_pop_no_ovf", 32'(rx_overrun), 0);
`endif
        void'(fifo_q.pop_front());
        fifo_q.push_back(8'hA5);
        tick();
        for (int i = 0; i < DEPTH; i++) read_check(2'd0, "drain");

        // ---------------- reset mid-write ----------------
        tx_log.delete();
        uart_wd = $urandom;
        uart_wsz = 2'd3;
        uart_wenable = 1'b1;
        tick();
        uart_wenable = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        snap = wdone_cnt;
        #1;
        check("mid_rst_valid", 32'(tx_valid), 0);
        check("mid_rst_busy", 32'(w_busy), 0);
        repeat (3) tick();
        check("mid_rst_nodone", 32'(wdone_cnt - snap), 0);
        check("mid_rst_sent", 32'(tx_log.size()), 2);
        rstn = 1'b1;
        fifo_q.delete();
        tick();
        write_check(2'd1, 32'h0000ABCD, "post_rst");

        // ---------------- randomised traffic ----------------
        ready_mode = 2;
        for (int it = 0; it < 25; it++) begin
            rnd = $urandom;
            write_check(2'($urandom_range(0, 3)), rnd, "rnd_w");
            while (fifo_q.size() < 2) push(8'($urandom));
            c = $urandom_range(0, 3);
            while (fifo_q.size() >= c + 1) begin
                read_check(2'(c), "rnd_r");
                c = $urandom_range(0, 3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_io_resp.md
Name: uart_io_resp

Overview:
- Responder side of the core's UART request interface: services the exec stage's `uart_wenable`/`uart_renable` requests and returns `uart_wdone`/`uart_rdone`.
- Write path serialises a 1–4 byte word into a byte-wide TX stream.
- Read path buffers incoming RX bytes in a FIFO and assembles 1–4 of them into a zero-extended word.
- Sits between the exec stage and the byte-level UART transceiver.

Parameters:
- RX_FIFO_DEPTH, 16: RX byte FIFO entries; power of two, minimum 2.
- RX_PTR_W, 4: log2(RX_FIFO_DEPTH).

Ports:
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- uart_wenable  in  1  write request strobe, one cycle.
- uart_wsz  in  2  write size; byte count = uart_wsz+1.
- uart_wd  in  32  write data, right-aligned.
- uart_wdone  out  1  write-complete pulse.
- uart_renable  in  1  read request strobe, one cycle.
- uart_rsz  in  2  read size; byte count = uart_rsz+1.
- uart_rd  out  32  read data, zero-extended.
- uart_rdone  out  1  read-complete pulse; uart_rd valid this cycle.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe per received byte.
- w_busy  out  1  write engine not idle.
- r_busy  out  1  read engine not idle.

Behaviour:
- Reset: all outputs 0; FIFO emptied; both engines idle; partial words discarded. Reset mid-transfer aborts with no done pulse.
- Write engine states: W_IDLE -> W_SEND -> W_DONE -> W_IDLE.
  - W_IDLE: on uart_wenable, latch data and count n=wsz+1; go to W_SEND.
  - W_SEND:
    - tx_valid=1 from the next cycle.
    - Bytes are sent most-significant first within the selected width. Example: wsz=3 sends wd[31:24], [23:16], [15:8], [7:0]; wsz=0 sends wd[7:0] only.
    - tx_data is held stable while tx_valid & ~tx_ready.
    - The next byte is presented in the cycle after each handshake.
  - After the final handshake, go to W_DONE. uart_wdone=1 for exactly one cycle, tx_valid=0, then W_IDLE.
  - Minimum latency, with tx_ready tied high: request at edge k; byte handshakes at cycles k+1..k+n; uart_wdone high in cycle k+n+1.
- Read engine states: R_IDLE -> R_COLLECT -> R_DONE -> R_IDLE.
  - R_IDLE: on uart_renable, latch n=rsz+1, clear the accumulator, go to R_COLLECT.
  - R_COLLECT: pop one byte per cycle while the FIFO is non-empty; acc = {acc[23:0], byte}. Stall without timeout while the FIFO is empty.
  - After n pops, go to R_DONE: uart_rd = acc (upper bytes 0), uart_rdone=1 for one cycle.
  - uart_rd holds its value until the next rdone; it is cleared only by reset.
  - First received byte lands in the most-significant populated byte: rsz=1 with bytes 0x12, 0x34 gives 0x00001234.
  - Minimum latency, with n bytes already buffered: request at edge k; pops at k+1..k+n; uart_rdone in cycle k+n+1.
- Engines are independent; simultaneous read and write proceed in parallel.
- A request strobe while its engine is busy is ignored; w_busy/r_busy are high in every non-idle state.
- RX FIFO push rules:
  - rx_valid pushes rx_data regardless of read-engine state; there is no bypass.
  - Full with rx_valid and a same-cycle pop: the push is accepted.
  - Full without a pop: the byte is dropped and the FIFO contents are unchanged.
- Pointers wrap modulo RX_FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter (RX_PTR_W+1 bits).

Optional Feature:
- Macro UART_IO_OVERRUN_EN.
- Defined:
  - Adds output rx_overrun (1 bit), a sticky flag set when a byte is dropped on a full FIFO.
  - Adds input rx_overrun_clr (1 bit), which clears the flag; set wins over a same-cycle clear.
  - Both reset to 0.
- Undefined: the ports are absent and drops are silent; FIFO behaviour is otherwise identical.

Test Plan:
- wsz=3, wd=0xDEADBEEF, tx_ready=1 -> tx_data DE, AD, BE, EF on consecutive cycles; uart_wdone one cycle later; w_busy low after.
- wsz=0, wd=0x00000041, tx_ready low 5 cycles then high -> tx_data=0x41 held stable throughout; a single handshake; uart_wdone pulse.
- RX bytes 0x12, 0x34, 0x56 pushed first, then renable with rsz=2 -> uart_rd=0x00123456 with uart_rdone 4 cycles after the request; FIFO empty afterwards.
- renable rsz=3 on an empty FIFO, bytes arrive at 10-cycle gaps -> r_busy stays high, no rdone until the 4th byte, then uart_rd equals the 4 bytes in order.
- Push 17 bytes with RX_FIFO_DEPTH=16 and no reads -> the 17th byte is dropped; rx_overrun=1 (macro on); 16 subsequent single-byte reads return bytes 1..16.
- Assert rstn low mid-write, after 2 of 4 bytes -> tx_valid=0 and no wdone; a subsequent wsz=1, wd=0xABCD sends AB, CD normally.
